// File: rtl/rv32_mvu_job_arbiter.sv
// Round-robin arbiter sharing one MVU between all barrel-core harts.
// Queues per-hart start pulses, latches the winner's config, and returns completion or timeout as an irq.
module rv32_mvu_job_arbiter #(
  parameter int          NUM_HARTS   = 8,
  parameter int          HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  parameter int          CFG_W       = 358,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_HARTS-1:0]       mvu_start_i,
  input  logic [CFG_W*NUM_HARTS-1:0] mvu_cfg_i,
  input  logic                       mvu_done_i,
  output logic                       mvu_start_o,
  output logic [CFG_W-1:0]           mvu_cfg_o,
  output logic [HART_W-1:0]          mvu_hart_o,
  output logic                       mvu_abort_o,
  output logic [NUM_HARTS-1:0]       mvu_irq_o,
  output logic [NUM_HARTS-1:0]       mvu_err_o,
  output logic                       busy_o,
  output logic [NUM_HARTS-1:0]       pending_o
);

  localparam int                   CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(TIMEOUT_CYC);
  localparam bit                   WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [NUM_HARTS-1:0] HOT0     = NUM_HARTS'(1);
  localparam logic [HART_W-1:0]    LAST_IDX = HART_W'(NUM_HARTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_IRQ   = 2'd3
  } state_e;

  state_e               state_q;
  logic [NUM_HARTS-1:0] pend_q;
  logic [NUM_HARTS-1:0] pend_d;
  logic [HART_W-1:0]    rr_q;
  logic [HART_W-1:0]    rr_d;
  logic [CFG_W-1:0]     cfg_q;
  logic [HART_W-1:0]    hart_q;
  logic [NUM_HARTS-1:0] err_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 win_found;
  logic [HART_W-1:0]    win_idx;
  logic                 grant;
  logic [NUM_HARTS-1:0] grant_mask;
  logic                 expire;

  // Lowest pending index overall is the wrap-around fallback; lowest at or above rr overrides it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_HARTS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        win_found = 1'b1;
        win_idx   = HART_W'(k);
      end
    end
    for (int k = NUM_HARTS - 1; k >= 0; k--) begin
      if (pend_q[k] && (HART_W'(k) >= rr_q)) begin
        win_idx = HART_W'(k);
      end
    end
  end

  assign grant      = (state_q == S_IDLE) && win_found;
  assign grant_mask = grant ? (HOT0 << win_idx) : '0;
  assign rr_d       = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  // A start pulse on the grant edge re-queues the same hart: set beats clear.
  assign pend_d     = (pend_q & ~grant_mask) | mvu_start_i;
  assign expire     = WD_EN && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
      cfg_q   <= '0;
      hart_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            cfg_q          <= mvu_cfg_i[int'(win_idx)*CFG_W +: CFG_W];
            hart_q         <= win_idx;
            err_q[win_idx] <= 1'b0;
            rr_q           <= rr_d;
            state_q        <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= CNT_LOAD;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (mvu_done_i) begin
            state_q <= S_IRQ;
          end else if (expire) begin
            err_q[hart_q] <= 1'b1;
            state_q       <= S_IRQ;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_IRQ: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mvu_start_o = (state_q == S_START);
  // A done arriving in the expiry cycle suppresses the abort.
  assign mvu_abort_o = (state_q == S_RUN) && expire && !mvu_done_i;
  assign mvu_irq_o   = (state_q == S_IRQ) ? (HOT0 << hart_q) : '0;
  assign mvu_cfg_o   = cfg_q;
  assign mvu_hart_o  = hart_q;
  assign mvu_err_o   = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign pending_o   = pend_q;

endmodule

// File: tb/tb_rv32_mvu_job_arbiter.sv
// Bench for rv32_mvu_job_arbiter: directed scenarios plus random traffic against a job-age reference model.
module tb_rv32_mvu_job_arbiter;

  localparam int N  = 8;
  localparam int CW = 358;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      start_i;
  logic [CW*N-1:0]   cfg_i;
  logic              done_i;
  logic              mvu_start_o;
  logic [CW-1:0]     mvu_cfg_o;
  logic [2:0]        mvu_hart_o;
  logic              mvu_abort_o;
  logic [N-1:0]      mvu_irq_o;
  logic [N-1:0]      mvu_err_o;
  logic              busy_o;
  logic [N-1:0]      pending_o;
  logic [29:0]       dut_bus;

  int nvec = 0;
  int nerr = 0;

  rv32_mvu_job_arbiter #(
    .NUM_HARTS  (N),
    .HART_W     (3),
    .CFG_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mvu_start_i(start_i),
    .mvu_cfg_i  (cfg_i),
    .mvu_done_i (done_i),
    .mvu_start_o(mvu_start_o),
    .mvu_cfg_o  (mvu_cfg_o),
    .mvu_hart_o (mvu_hart_o),
    .mvu_abort_o(mvu_abort_o),
    .mvu_irq_o  (mvu_irq_o),
    .mvu_err_o  (mvu_err_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  assign dut_bus = {mvu_start_o, mvu_abort_o, mvu_irq_o, mvu_err_o, busy_o, pending_o, mvu_hart_o};

  // Reference model: a job is tracked by its age in cycles since the grant edge
  // (1 = start cycle, age a >= 2 = run cycle a-1); m_irq marks the completion cycle.
  bit [N-1:0]  m_pend;
  bit [N-1:0]  m_err;
  int          m_rr;
  int          m_age;
  int          m_owner;
  bit          m_irq;
  logic [CW-1:0] m_cfg;
  int          d_grants[$];

  function automatic logic [29:0] exp_bus();
    logic       st, ab, bz;
    logic [N-1:0] irq;
    st  = (m_age == 1);
    ab  = (m_age >= 2) && ((m_age - 1) == TO) && !done_i;
    irq = m_irq ? (N'(1) << m_owner) : '0;
    bz  = (m_age != 0) || m_irq;
    return {st, ab, irq, m_err, bz, m_pend, 3'(m_owner)};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_err = '0; m_rr = 0; m_age = 0; m_owner = 0; m_irq = 0; m_cfg = '0;
  endtask

  task automatic model_step();
    int w;
    if (m_irq) begin
      m_irq = 0;
    end else if (m_age == 0) begin
      if (m_pend != 0) begin
        w = -1;
        for (int o = 0; o < N; o++) begin
          if (w < 0 && m_pend[(m_rr + o) % N]) w = (m_rr + o) % N;
        end
        m_cfg     = cfg_i[w*CW +: CW];
        m_owner   = w;
        m_err[w]  = 0;
        m_pend[w] = 0;
        m_rr      = (w + 1) % N;
        m_age     = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (done_i) begin
      m_irq = 1; m_age = 0;
    end else if ((m_age - 1) == TO) begin
      m_err[m_owner] = 1; m_irq = 1; m_age = 0;
    end else begin
      m_age++;
    end
    m_pend = m_pend | start_i;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    start_i = '0;
    done_i  = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int b = 0; b < CW*N; b++) cfg_i[b] = 1'($urandom_range(0, 1));
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if (dut_bus !== 30'd0) begin
      nerr++; $display("FAIL reset_outputs got=%h exp=%h", dut_bus, 30'd0);
    end
    nvec++;
    if (mvu_cfg_o !== '0) begin
      nerr++; $display("FAIL reset_cfg got=%h exp=0", mvu_cfg_o);
    end
    do_reset();
    @(negedge clk);
    nvec++;
    if (dut_bus !== exp_bus()) begin
      nerr++; $display("FAIL reset_release got=%h exp=%h", dut_bus, exp_bus());
    end
    tick();
  endtask

  task automatic test_single_job();
    do_reset();
    cfg_i[3*CW +: CW] = CW'(8'h5A);
    for (int c = 0; c < 15; c++) begin
      start_i = (c == 0) ? 8'h08 : 8'h00;
      done_i  = (c == 10);
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL single_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      nvec++;
      if (mvu_cfg_o !== m_cfg) begin
        nerr++; $display("FAIL single_cfg c=%0d got=%h exp=%h", c, mvu_cfg_o, m_cfg);
      end
      if (c == 2) begin
        nvec++;
        if ({mvu_start_o, mvu_hart_o, mvu_cfg_o} !== {1'b1, 3'd3, CW'(8'h5A)}) begin
          nerr++; $display("FAIL single_start got=%b/%0d/%h exp=1/3/5a", mvu_start_o, mvu_hart_o, mvu_cfg_o);
        end
      end
      if (c == 11) begin
        nvec++;
        if (mvu_irq_o !== 8'b0000_1000) begin
          nerr++; $display("FAIL single_irq got=%b exp=00001000", mvu_irq_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    do_reset();
    d_grants.delete();
    for (int c = 0; c < 30; c++) begin
      start_i = (c == 0) ? 8'h25 : 8'h00;
      done_i  = (m_age == 3);
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL fair_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (mvu_start_o) d_grants.push_back(int'(mvu_hart_o));
      tick();
    end
    nvec++;
    if (d_grants.size() != 3 || d_grants[0] != 0 || d_grants[1] != 2 || d_grants[2] != 5) begin
      nerr++; $display("FAIL fair_order got=%p exp='{0,2,5}", d_grants);
    end
    nvec++;
    if (pending_o !== 8'h00) begin
      nerr++; $display("FAIL fair_drain got=%h exp=00", pending_o);
    end
    d_grants.delete();
    for (int c = 0; c < 8; c++) begin
      start_i = (c == 0) ? 8'h21 : 8'h00;
      done_i  = (m_age == 3);
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL fair_wrap_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (mvu_start_o) d_grants.push_back(int'(mvu_hart_o));
      tick();
    end
    nvec++;
    if (d_grants.size() < 1 || d_grants[0] != 0) begin
      nerr++; $display("FAIL fair_wrap got=%p exp first grant 0", d_grants);
    end
  endtask

  task automatic test_requeue();
    int n1;
    do_reset();
    n1 = 0;
    for (int c = 0; c < 30; c++) begin
      start_i = (c == 0 || c == 4 || c == 5 || c == 7) ? 8'h02 : 8'h00;
      done_i  = (m_age == 6);
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL requeue_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (mvu_start_o && mvu_hart_o == 3'd1) n1++;
      tick();
    end
    nvec++;
    if (n1 != 2 || pending_o !== 8'h00) begin
      nerr++; $display("FAIL requeue_count got=%0d/%h exp=2/00", n1, pending_o);
    end
    do_reset();
    for (int c = 0; c < 14; c++) begin
      start_i = (c <= 1) ? 8'h10 : 8'h00;
      done_i  = (m_age == 3);
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL grant_edge_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (c == 2) begin
        nvec++;
        if ({mvu_start_o, mvu_hart_o, pending_o[4]} !== {1'b1, 3'd4, 1'b1}) begin
          nerr++; $display("FAIL grant_edge_pend got=%b/%0d/%b exp=1/4/1", mvu_start_o, mvu_hart_o, pending_o[4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 23; c++) begin
        start_i = (c == 0) ? 8'h04 : 8'h00;
        done_i  = (pass == 1) && (c == 18);
        @(negedge clk);
        nvec++;
        if (dut_bus !== exp_bus()) begin
          nerr++; $display("FAIL wd_bus p=%0d c=%0d got=%h exp=%h", pass, c, dut_bus, exp_bus());
        end
        if (c == 17 || c == 18) begin
          nvec++;
          if (mvu_abort_o !== (pass == 0 && c == 18)) begin
            nerr++; $display("FAIL wd_abort p=%0d c=%0d got=%b exp=%b", pass, c, mvu_abort_o, (pass == 0 && c == 18));
          end
        end
        if (c == 19) begin
          nvec++;
          if ({mvu_irq_o, mvu_err_o[2]} !== {8'h04, (pass == 0)}) begin
            nerr++; $display("FAIL wd_irq_err p=%0d got=%h/%b exp=04/%b", pass, mvu_irq_o, mvu_err_o[2], (pass == 0));
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_midjob();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      start_i = (c == 0) ? 8'h01 : ((c == 3) ? 8'hF0 : 8'h00);
      done_i  = 1'b0;
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL midjob_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (c < 5) tick();
    end
    nvec++;
    if ({busy_o, pending_o} !== {1'b1, 8'hF0}) begin
      nerr++; $display("FAIL midjob_pre got=%b/%h exp=1/f0", busy_o, pending_o);
    end
    start_i = 8'h00;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (dut_bus !== 30'd0 || mvu_cfg_o !== '0) begin
      nerr++; $display("FAIL midjob_async got=%h exp=0", dut_bus);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (mvu_irq_o !== 8'h00 || pending_o !== 8'h00) begin
      nerr++; $display("FAIL midjob_noirq got=%h/%h exp=00/00", mvu_irq_o, pending_o);
    end
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      start_i = (c == 0) ? 8'h40 : 8'h00;
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL midjob_after c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      if (c == 2) begin
        nvec++;
        if ({mvu_start_o, mvu_hart_o} !== {1'b1, 3'd6}) begin
          nerr++; $display("FAIL midjob_restart got=%b/%0d exp=1/6", mvu_start_o, mvu_hart_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int h = 0; h < N; h++) start_i[h] = ($urandom_range(0, 15) == 0);
      done_i = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) cfg_i[$urandom_range(0, CW*N/32 - 1)*32 +: 32] = $urandom;
      @(negedge clk);
      nvec++;
      if (dut_bus !== exp_bus()) begin
        nerr++; $display("FAIL rand_bus c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
      end
      nvec++;
      if (mvu_cfg_o !== m_cfg) begin
        nerr++; $display("FAIL rand_cfg c=%0d got=%h exp=%h", c, mvu_cfg_o, m_cfg);
      end
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = '0;
    done_i  = 1'b0;
    cfg_i   = '0;
    model_reset();
    test_reset();
    test_single_job();
    test_fairness();
    test_requeue();
    test_watchdog();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
